round_robin_merge: RTL and testbench
====================================

ROUND_ROBIN_MERGE -- requirements
Module: round_robin_merge

Interface
REQ-001 SHALL have parameter N, default 4, the number of source channels (legal range 2..16).
REQ-002 SHALL have parameter DW, default 32, the payload width in bits.
REQ-003 SHALL use the derived width IW = $clog2(N) for the source index.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 i_clk  input  1  clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  reset; asynchronous, active-high.
REQ-007 src_rdys  input  N  per-source request valid.
REQ-008 src_acks  output  N  per-source accept; at most one bit set in any cycle.
REQ-009 src_datas  input  N x DW  per-source payload.
REQ-010 dst_rdy  output  1  registered output valid.
REQ-011 dst_ack  input  1  downstream accept.
REQ-012 dst_data  output  DW  registered payload.
REQ-013 dst_id  output  IW  index of the source that supplied dst_data.

Function
REQ-014 SHALL merge N rdy/ack sources into one rdy/ack destination through a single registered output stage (the many-to-one counterpart of broadcast).
REQ-015 SHALL compute can_take = !dst_rdy || dst_ack combinationally.
REQ-016 SHALL hold a round-robin pointer ptr (IW bits, range 0..N-1).
REQ-017 SHALL select as grant g the first index i with src_rdys[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-018 SHALL assert src_acks[g]=1 only when can_take=1 and at least one src_rdys bit is set; all other src_acks bits SHALL be 0.
REQ-019 SHALL, on a cycle with a grant, load dst_data <= src_datas[g], dst_id <= g, dst_rdy <= 1, and ptr <= g+1, wrapping to 0 when g=N-1 (this holds for N not a power of two).
REQ-020 SHALL, on a cycle with can_take=1 and no src_rdys bit set, load dst_rdy <= 0 and leave ptr, dst_data and dst_id unchanged.
REQ-021 SHALL, while dst_rdy=1 and dst_ack=0, hold dst_rdy, dst_data, dst_id and ptr stable and keep all src_acks at 0.
REQ-022 SHALL have a latency of 1 cycle from src_acks to dst_rdy, and sustain 1 beat per cycle when dst_ack stays high.
REQ-023 SHALL, when dst_ack=1 and a new grant occur in the same cycle, replace the output register with no bubble cycle.
REQ-024 SHALL ensure that no source with src_rdys held high waits more than N-1 grants (starvation freedom).
REQ-025 SHALL produce src_acks combinationally from src_rdys, ptr, dst_rdy and dst_ack, with no path from src_datas.
REQ-026 SHALL NOT rely on src_rdys being stable, since sources hold rdy and data until acked per protocol, but SHALL still produce a legal one-hot-or-zero src_acks for any input.

Reset
REQ-027 SHALL, while i_rst=1, force dst_rdy=0, ptr=0, dst_id=0 and dst_data=0, which in turn forces src_acks=0 when no source is ready.
REQ-028 SHALL, on reset asserted mid-operation, discard any held output beat; that beat SHALL NOT be re-presented after reset.
REQ-029 SHALL resume arbitration from index 0 on the first clock edge after reset deasserts.

Structure
REQ-030 SHALL put no new typedefs in a shared package; it SHALL use only the common rdy/ack and clock port macros.
REQ-031 SHALL implement the rotate-priority search as one combinational sub-module, rr_pick (inputs: request vector and ptr; outputs: grant index and any-valid).
REQ-032 SHALL keep all flip-flops in round_robin_merge, namely ptr and the output stage.

Verification
REQ-033 Reset: i_rst=1 with src_rdys=4'b1111 -> dst_rdy=0 and src_acks=0 during reset; first post-reset grant = source 0.
REQ-034 Fairness: N=4, all rdys held high, dst_ack=1 constantly -> dst_id sequence 0,1,2,3,0,... with one beat per cycle.
REQ-035 Backpressure: dst_ack=0 for 5 cycles with src_rdys=4'b0100 and data 0xA5 -> dst_rdy=1, dst_data=0xA5 and dst_id=2 stable, src_acks=0; ack releases -> src_acks[2] pulses once.
REQ-036 Wrap: ptr=3, src_rdys=4'b0011 -> grant source 0, then ptr=1, and the next grant is source 1.
REQ-037 Non-power-of-two: N=3, all rdys high -> dst_id cycles 0,1,2,0 and never shows 3.
REQ-038 Idle: a single beat acked with src_rdys=0 -> dst_rdy falls the next cycle, and ptr plus the last dst_data/dst_id are retained.

Source files
------------

// File: rtl/round_robin_merge_pkg.sv
// Shared helpers for the round-robin merge: modular index arithmetic used by
// both the arbiter search and the pointer update.
package round_robin_merge_pkg;

    // (base + off) mod n, assuming base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

    function automatic int next_index(input int idx, input int n);
        return wrap_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/round_robin_merge_rr_pick.sv
// Rotate-priority search: first set request at or after ptr, wrapping at N.
// Purely combinational so the merge's acks depend only on rdys and ptr.
module rr_pick
    import round_robin_merge_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [IW-1:0] offset;

    // rot[k] is the request k positions after ptr, so bit 0 has top priority.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[IW'(wrap_add(int'(ptr), gi, N))];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = IW'(k);
            end
        end
    end

    assign any   = |req;
    assign grant = IW'(wrap_add(int'(ptr), int'(offset), N));

endmodule

// File: rtl/round_robin_merge.sv
// N-to-1 rdy/ack merge with round-robin arbitration feeding a single
// registered output stage.
module round_robin_merge
    import round_robin_merge_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 32,
    localparam int IW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    src_rdys,
    output logic [N-1:0]    src_acks,
    input  logic [N*DW-1:0] src_datas,
    output logic            dst_rdy,
    input  logic            dst_ack,
    output logic [DW-1:0]   dst_data,
    output logic [IW-1:0]   dst_id
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic          dst_rdy_reg;
    logic [DW-1:0] dst_data_reg;
    logic [IW-1:0] dst_id_reg;

    logic [IW-1:0] grant;
    logic          any;
    logic          can_take;
    logic          take;
    logic [DW-1:0] src_words [N];
    logic [DW-1:0] data_sel;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (src_rdys),
        .ptr   (ptr_reg),
        .grant (grant),
        .any   (any)
    );

    assign can_take = !dst_rdy_reg || dst_ack;
    // Nothing is accepted while reset is held, so no source loses a beat to it.
    assign take     = can_take && any && !i_rst;
    assign ptr_next = IW'(next_index(int'(grant), N));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            assign src_words[gi] = src_datas[gi*DW +: DW];
            assign src_acks[gi]  = take && (grant == IW'(gi));
        end
    endgenerate

    assign data_sel = src_words[grant];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_reg      <= '0;
            dst_rdy_reg  <= 1'b0;
            dst_data_reg <= '0;
            dst_id_reg   <= '0;
        end else if (can_take) begin
            if (take) begin
                ptr_reg      <= ptr_next;
                dst_rdy_reg  <= 1'b1;
                dst_data_reg <= data_sel;
                dst_id_reg   <= grant;
            end else begin
                // Idle drain: keep ptr and last payload/id for observability.
                dst_rdy_reg  <= 1'b0;
            end
        end
    end

    assign dst_rdy  = dst_rdy_reg;
    assign dst_data = dst_data_reg;
    assign dst_id   = dst_id_reg;

endmodule

// File: tb/tb_round_robin_merge.sv
// Self-checking bench for round_robin_merge: directed scenarios plus random
// traffic checked against a cycle-level model of the arbitration rules.
module tb_round_robin_merge;

    logic         clk;
    logic         rst;
    logic [3:0]   src_rdys;
    logic [127:0] src_datas;
    logic         dst_ack;
    logic [3:0]   src_acks;
    logic         dst_rdy;
    logic [31:0]  dst_data;
    logic [1:0]   dst_id;

    logic [2:0]   rdys3;
    logic [23:0]  datas3;
    logic         ack3;
    logic [2:0]   acks3;
    logic         rdy3;
    logic [7:0]   data3;
    logic [1:0]   id3;

    int passed = 0;
    int total  = 0;

    // Reference model state: output register contents and rotation pointer.
    int          m_ptr;
    logic        m_vld;
    logic [31:0] m_data;
    int          m_id;

    round_robin_merge #(.N(4), .DW(32)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .src_rdys  (src_rdys),
        .src_acks  (src_acks),
        .src_datas (src_datas),
        .dst_rdy   (dst_rdy),
        .dst_ack   (dst_ack),
        .dst_data  (dst_data),
        .dst_id    (dst_id)
    );

    round_robin_merge #(.N(3), .DW(8)) dut3 (
        .i_clk     (clk),
        .i_rst     (rst),
        .src_rdys  (rdys3),
        .src_acks  (acks3),
        .src_datas (datas3),
        .dst_rdy   (rdy3),
        .dst_ack   (ack3),
        .dst_data  (data3),
        .dst_id    (id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // First ready source scanning p, p+1, ... with wrap; -1 if none.
    function automatic int pick(input logic [3:0] req, input int p);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 1'b0;
        m_data = '0;
        m_id   = 0;
    endtask

    // Called at a falling edge with inputs already driven; checks, advances
    // the model across the next rising edge, returns at the following fall.
    task automatic tick(input string tag, output logic [3:0] ea, output logic [3:0] oa);
        int   g;
        logic can;
        #1;
        can = !m_vld || dst_ack;
        g   = pick(src_rdys, m_ptr);
        ea  = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
        oa  = src_acks;
        $display("%s rdys=%b ack=%b acks=%b out rdy=%b id=%0d data=%h",
                 tag, src_rdys, dst_ack, src_acks, dst_rdy, dst_id, dst_data);
        check({tag, ".acks"},   32'(src_acks), 32'(ea));
        check({tag, ".onehot"}, 32'($countones(src_acks) <= 1), 32'd1);
        check({tag, ".rdy"},    32'(dst_rdy), 32'(m_vld));
        check({tag, ".data"},   dst_data, m_data);
        check({tag, ".id"},     32'(dst_id), 32'(m_id));
        if (can) begin
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_data = src_datas[g*32 +: 32];
                m_id   = g;
                m_ptr  = (g + 1) % 4;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  ea;
        logic [3:0]  oa;
        logic [3:0]  pend;
        logic [31:0] pdata [4];
        int          waits [4];

        rst       = 1'b1;
        src_rdys  = 4'b1111;
        src_datas = '0;
        dst_ack   = 1'b0;
        rdys3     = '0;
        datas3    = '0;
        ack3      = 1'b0;
        pend      = '0;
        for (int i = 0; i < 4; i++) begin
            pdata[i] = '0;
            waits[i] = 0;
        end
        model_reset();

        // Reset with every source ready: nothing granted, output cleared.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset.rdy",  32'(dst_rdy), 32'd0);
        check("reset.acks", 32'(src_acks), 32'd0);
        check("reset.data", dst_data, 32'd0);
        check("reset.id",   32'(dst_id), 32'd0);
        check("reset.rdy3", 32'(rdy3), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness: all ready, ack always high -> ids 0,1,2,3,0,... every cycle.
        dst_ack   = 1'b1;
        src_datas = {32'hD003_0003, 32'hD002_0002, 32'hD001_0001, 32'hD000_0000};
        for (int k = 0; k < 8; k++) begin
            tick("fair", ea, oa);
            check("fair.seq", 32'(dst_id), 32'(k % 4));
            check("fair.beat", 32'(dst_rdy), 32'd1);
        end

        // Backpressure: beat from source 2 held steady while downstream stalls.
        src_rdys            = 4'b0100;
        src_datas[95:64]    = 32'hA5;
        tick("bp_load", ea, oa);
        dst_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick("bp_hold", ea, oa);
            check("bp.rdy",  32'(dst_rdy), 32'd1);
            check("bp.data", dst_data, 32'hA5);
            check("bp.id",   32'(dst_id), 32'd2);
            check("bp.acks", 32'(src_acks), 32'd0);
        end
        dst_ack = 1'b1;
        tick("bp_release", ea, oa);
        check("bp.pulse", 32'(oa), 32'b0100);

        // Idle: no requests -> output drains, last payload and id retained.
        src_rdys = 4'b0000;
        tick("idle", ea, oa);
        check("idle.rdy",  32'(dst_rdy), 32'd0);
        check("idle.data", dst_data, 32'hA5);
        check("idle.id",   32'(dst_id), 32'd2);

        // Wrap: pointer sits at 3 after the source-2 grant; 0 then 1 follow.
        src_rdys         = 4'b0011;
        src_datas[31:0]  = 32'h11;
        src_datas[63:32] = 32'h22;
        tick("wrap0", ea, oa);
        check("wrap.first.id",   32'(dst_id), 32'd0);
        check("wrap.first.data", dst_data, 32'h11);
        tick("wrap1", ea, oa);
        check("wrap.second.id",   32'(dst_id), 32'd1);
        check("wrap.second.data", dst_data, 32'h22);

        // Reset mid-operation discards a stalled beat for good.
        src_rdys           = 4'b1000;
        src_datas[127:96]  = 32'hDEAD;
        tick("mid_load", ea, oa);
        dst_ack = 1'b0;
        tick("mid_hold", ea, oa);
        src_rdys = 4'b0000;
        rst      = 1'b1;
        #1;
        check("midrst.rdy",  32'(dst_rdy), 32'd0);
        check("midrst.data", dst_data, 32'd0);
        check("midrst.id",   32'(dst_id), 32'd0);
        check("midrst.acks", 32'(src_acks), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick("post_rst", ea, oa);
        check("post_rst.rdy", 32'(dst_rdy), 32'd0);

        // N=3: all ready, ack high -> ids cycle 0,1,2 and never reach 3.
        rdys3  = 3'b111;
        ack3   = 1'b1;
        datas3 = {8'h32, 8'h31, 8'h30};
        for (int j = 0; j < 8; j++) begin
            #1;
            check("n3.acks", 32'(acks3), 32'(1 << (j % 3)));
            check("n3.rdy",  32'(rdy3), 32'(j > 0));
            if (j > 0) begin
                check("n3.id",   32'(id3), 32'((j - 1) % 3));
                check("n3.data", 32'(data3), 32'(8'h30 + (j - 1) % 3));
            end
            @(negedge clk);
        end
        rdys3 = '0;

        // Random traffic: sources hold rdy/data until acked; random stalls.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end
                src_datas[i*32 +: 32] = pend[i] ? pdata[i] : $urandom;
            end
            src_rdys = pend;
            dst_ack  = ($urandom_range(0, 3) != 0);
            tick("rand", ea, oa);
            if (oa != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (oa[i]) begin
                        check("rand.starve", 32'(waits[i] <= 3), 32'd1);
                        waits[i] = 0;
                    end else if (pend[i]) begin
                        waits[i]++;
                    end
                end
            end
            pend = pend & ~oa;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
